// File: rtl/posit_shift_arbiter_pkg.sv
// Shared constants and types for the posit shift arbiter: default widths,
// requester count and the result-owner encoding.
package posit_shift_arbiter_pkg;

   localparam int POSIT_N = 16;
   localparam int POSIT_S = 4;
   localparam int NUM_REQ = 2;

   typedef enum logic {
      OWNER_0 = 1'b0,
      OWNER_1 = 1'b1
   } owner_e;

endpackage

// File: rtl/posit_shl_sticky.sv
// Combinational logarithmic left shifter with sticky: each stage shifts by
// 2^i when amt_i[i] is set and ORs the bits it pushes out into sticky_o.
module posit_shl_sticky #(
   parameter int N = 16,
   parameter int S = 4
) (
   input  logic [N-1:0] data_i,
   input  logic [S-1:0] amt_i,
   output logic [N-1:0] data_o,
   output logic         sticky_o
);

   logic [N-1:0] v;
   logic         st;

   always_comb begin
      v  = data_i;
      st = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (amt_i[i]) begin
            // A stage at least as wide as the word discards everything left.
            if ((1 << i) >= N) begin
               st = st | (|v);
               v  = '0;
            end else begin
               st = st | (|(v >> (N - (1 << i))));
               v  = v << (1 << i);
            end
         end
      end
   end

   assign data_o   = v;
   assign sticky_o = st;

endmodule

// File: rtl/posit_shift_arbiter.sv
// Round-robin arbiter sharing one shift/sticky unit between two requesters,
// with a single registered result slot routed back to the granted requester.
module posit_shift_arbiter
   import posit_shift_arbiter_pkg::*;
#(
   parameter int N = POSIT_N,
   parameter int S = POSIT_S
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_data,
   input  logic [S-1:0] req0_amt,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_data,
   input  logic [S-1:0] req1_amt,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [N-1:0] rsp0_data,
   output logic         rsp0_sticky,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [N-1:0] rsp1_data,
   output logic         rsp1_sticky
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; requests stay valid with stable data until accepted.

   logic               out_valid_q, out_valid_d;
   owner_e             out_owner_q, out_owner_d;
   logic [N-1:0]       out_data_q, out_data_d;
   logic               out_sticky_q, out_sticky_d;
   owner_e             last_grant_q, last_grant_d;

   logic [NUM_REQ-1:0] req_valid;
   logic               owner_ready;
   logic               free;
   logic               fire;
   owner_e             grant;
   logic [N-1:0]       sel_data;
   logic [S-1:0]       sel_amt;
   logic [N-1:0]       shl_data;
   logic               shl_sticky;

   assign req_valid = {req1_valid, req0_valid};

   always_comb begin
      owner_ready = (out_owner_q == OWNER_1) ? rsp1_ready : rsp0_ready;
      free        = !out_valid_q || owner_ready;

      grant = OWNER_0;
      if (&req_valid) begin
         grant = (last_grant_q == OWNER_0) ? OWNER_1 : OWNER_0;
      end else if (req_valid[1]) begin
         grant = OWNER_1;
      end

      fire     = free && (|req_valid);
      sel_data = (grant == OWNER_1) ? req1_data : req0_data;
      sel_amt  = (grant == OWNER_1) ? req1_amt  : req0_amt;
   end

   assign req0_ready = free && (grant == OWNER_0);
   assign req1_ready = free && (grant == OWNER_1);

   posit_shl_sticky #(
      .N (N),
      .S (S)
   ) u_shl (
      .data_i   (sel_data),
      .amt_i    (sel_amt),
      .data_o   (shl_data),
      .sticky_o (shl_sticky)
   );

   always_comb begin
      out_valid_d  = out_valid_q;
      out_owner_d  = out_owner_q;
      out_data_d   = out_data_q;
      out_sticky_d = out_sticky_q;
      last_grant_d = last_grant_q;
      if (fire) begin
         out_valid_d  = 1'b1;
         out_owner_d  = grant;
         out_data_d   = shl_data;
         out_sticky_d = shl_sticky;
         last_grant_d = grant;
      end else if (free) begin
         out_valid_d = 1'b0;
      end
   end

   // last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_owner_q  <= OWNER_0;
         out_data_q   <= '0;
         out_sticky_q <= 1'b0;
         last_grant_q <= OWNER_1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_owner_q  <= out_owner_d;
         out_data_q   <= out_data_d;
         out_sticky_q <= out_sticky_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp0_valid  = out_valid_q && (out_owner_q == OWNER_0);
   assign rsp1_valid  = out_valid_q && (out_owner_q == OWNER_1);
   assign rsp0_data   = out_data_q;
   assign rsp1_data   = out_data_q;
   assign rsp0_sticky = out_sticky_q;
   assign rsp1_sticky = out_sticky_q;

endmodule

// File: tb/tb_posit_shift_arbiter.sv
// Bench for posit_shift_arbiter: directed vectors for shift/sticky, tie-break,
// backpressure and reset, then a random phase scored against a queue model.
module tb_posit_shift_arbiter;

   localparam int N = 16;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [N-1:0] req0_data = '0, req1_data = '0;
   logic [S-1:0] req0_amt = '0, req1_amt = '0;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [N-1:0] rsp0_data, rsp1_data;
   logic         rsp0_sticky, rsp1_sticky;

   int n_checks = 0;
   int n_errors = 0;
   int n_acc    = 0;

   logic          mon_en = 1'b0;
   logic          acc0 = 1'b0, acc1 = 1'b0;
   logic [N:0]    exp_q0[$];
   logic [N:0]    exp_q1[$];
   logic [N:0]    e0, e1;

   posit_shift_arbiter #(.N(N), .S(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_data   (req0_data),
      .req0_amt    (req0_amt),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_data   (req1_data),
      .req1_amt    (req1_amt),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_data   (rsp0_data),
      .rsp0_sticky (rsp0_sticky),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_data   (rsp1_data),
      .rsp1_sticky (rsp1_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: shift into a double-width word; the upper half is what was lost.
   function automatic logic [N:0] ref_shl(input logic [N-1:0] d, input logic [S-1:0] a);
      logic [2*N-1:0] w;
      w = {{N{1'b0}}, d} << a;
      return {|w[2*N-1:N], w[N-1:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int ch, input logic [N-1:0] d, input logic [S-1:0] a,
                         input logic [N-1:0] ed, input logic es);
      if (ch == 0) begin
         req0_valid = 1'b1; req0_data = d; req0_amt = a;
      end else begin
         req1_valid = 1'b1; req1_data = d; req1_amt = a;
      end
      @(negedge clk);
      check("req_ready", (ch == 0) ? req0_ready : req1_ready, 1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("rsp_valid", (ch == 0) ? rsp0_valid : rsp1_valid, 1);
      check("rsp_other_valid", (ch == 0) ? rsp1_valid : rsp0_valid, 0);
      check("rsp_data", (ch == 0) ? rsp0_data : rsp1_data, ed);
      check("rsp_sticky", (ch == 0) ? rsp0_sticky : rsp1_sticky, es);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   // Scoreboard: sampled at negedge, where signals match the next rising edge.
   always @(negedge clk) begin
      acc0 <= req0_valid && req0_ready;
      acc1 <= req1_valid && req1_ready;
      if (mon_en && !rst) begin
         if (rsp0_valid && rsp0_ready) begin
            if (exp_q0.size() == 0) check("rsp0_unexpected", 1, 0);
            else begin
               e0 = exp_q0.pop_front();
               check("rsp0_result", {rsp0_sticky, rsp0_data}, e0);
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            if (exp_q1.size() == 0) check("rsp1_unexpected", 1, 0);
            else begin
               e1 = exp_q1.pop_front();
               check("rsp1_result", {rsp1_sticky, rsp1_data}, e1);
            end
         end
         if (req0_valid && req0_ready) begin
            exp_q0.push_back(ref_shl(req0_data, req0_amt));
            n_acc++;
         end
         if (req1_valid && req1_ready) begin
            exp_q1.push_back(ref_shl(req1_data, req1_amt));
            n_acc++;
         end
      end
   end

   initial begin
      // Reset state
      #2;
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_rsp_data", rsp0_data, 0);
      check("rst_rsp_sticky", rsp0_sticky, 0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Directed shift/sticky vectors
      do_req(0, 16'h00F3, 4'd4,  16'h0F30, 1'b0);
      do_req(1, 16'hF00F, 4'd12, 16'hF000, 1'b1);
      do_req(0, 16'h0001, 4'd15, 16'h8000, 1'b0);
      do_req(1, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0);
      do_req(0, 16'hFFFF, 4'd1,  16'hFFFE, 1'b1);
      do_req(1, 16'h8001, 4'd8,  16'h0100, 1'b1);

      // Tie and round-robin after reset: 0,1,0,1... with no gaps
      do_reset();
      req0_valid = 1'b1; req0_data = 16'h0003; req0_amt = 4'd1;
      req1_valid = 1'b1; req1_data = 16'h0005; req1_amt = 4'd2;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
         check("rr_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         check("rr_rsp0_valid", rsp0_valid, (i % 2 == 0) ? 1 : 0);
         check("rr_rsp1_valid", rsp1_valid, (i % 2 == 1) ? 1 : 0);
         check("rr_rsp_data", rsp0_data, (i % 2 == 0) ? 32'h0006 : 32'h0014);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // Backpressure on rsp0 blocks req1 until drained
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h0011; req0_amt = 4'd4;
      @(negedge clk);
      check("bp_req0_ready", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_data = 16'h1234; req1_amt = 4'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_rsp0_valid", rsp0_valid, 1);
         check("bp_rsp0_data", rsp0_data, 16'h0110);
         check("bp_req0_ready", req0_ready, 0);
         check("bp_req1_ready", req1_ready, 0);
      end
      rsp0_ready = 1'b1;
      #1;
      check("bp_release_req1_ready", req1_ready, 1);
      check("bp_release_req0_ready", req0_ready, 0);
      tick();
      req1_valid = 1'b0;
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp0_valid_after", rsp0_valid, 0);
      check("bp_rsp1_data", rsp1_data, 16'h2340);
      check("bp_rsp1_sticky", rsp1_sticky, 1);
      tick();

      // Reset mid-flight drops the pending result without a clock
      req1_valid = 1'b1; req1_data = 16'h0001; req1_amt = 4'd3;
      @(negedge clk);
      check("mf_req1_ready", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      check("mf_rsp1_valid", rsp1_valid, 1);
      check("mf_rsp1_data", rsp1_data, 16'h0008);
      #1;
      rst = 1'b1;
      #1;
      check("mf_rsp1_valid_async", rsp1_valid, 0);
      check("mf_rsp_data_async", rsp1_data, 0);
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h0003; req0_amt = 4'd1;
      req1_valid = 1'b1; req1_data = 16'h0005; req1_amt = 4'd2;
      #1;
      check("mf_tie_req0_ready", req0_ready, 1);
      check("mf_tie_req1_ready", req1_ready, 0);
      tick();
      check("mf_tie_rsp0_valid", rsp0_valid, 1);
      check("mf_tie_rsp0_data", rsp0_data, 16'h0006);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      tick();

      // Random valid/ready on both sides
      mon_en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_data  = N'($urandom);
            req0_amt   = S'($urandom_range(0, 15));
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_data  = N'($urandom);
            req1_amt   = S'($urandom_range(0, 15));
         end
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      mon_en = 1'b0;
      check("rand_q0_drained", exp_q0.size(), 0);
      check("rand_q1_drained", exp_q1.size(), 0);
      check("rand_traffic", (n_acc > 1000) ? 1 : 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
